// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end for the tank game: synchronizes and filters the
// PS/2 lines, receives 11-bit frames, and turns set-2 make/break scancodes
// into level-sensitive key states for both players.
//
// Handshake: byte_valid_o and frame_error_o are single-cycle pulses with no
// ready/back-pressure; the decoder consumes rx_byte in the byte_valid_o cycle.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [3:0] player_1_move_o,
    output logic [3:0] player_2_move_o,
    output logic       player_1_shoot_o,
    output logic       player_2_shoot_o,
    output logic       byte_valid_o,
    output logic       frame_error_o
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_s;
    logic          data_s;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    state_t        state;
    state_t        state_next;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] tcnt;
    logic [10:0]   shreg;
    logic [10:0]   full;
    logic          frame_done;
    logic          timeout;
    logic          good;
    logic [7:0]    rx_byte;
    logic          ext_pend;
    logic          brk_pend;

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];
    // Frame is shifted in from the top, so after 11 edges bit0 sits at [0].
    assign full   = {data_s, shreg[10:1]};
    assign good   = (full[0] == 1'b0) && (full[10] == 1'b1) && (^full[9:1] == 1'b1);

    // Two-flop synchronizers; lines idle high so reset to 1.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_i};
            data_sync <= {data_sync[0], ps2_data_i};
        end
    end

    // Glitch filter: level follows only after FILTER_LEN differing samples.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_s;
                filt_cnt <= '0;
                fall     <= ~clk_s;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // Receiver state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_next;
    end

    // Receiver next state: frame completion on the stop edge, abort on timeout.
    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (fall) state_next = RECV;
            end
            RECV: begin
                if (fall && bit_cnt == 4'd10) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end else if (!fall && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Receiver datapath: bit counter, shift register, timeout, result pulses.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bit_cnt       <= '0;
            tcnt          <= '0;
            shreg         <= '0;
            rx_byte       <= '0;
            byte_valid_o  <= 1'b0;
            frame_error_o <= 1'b0;
        end else begin
            byte_valid_o  <= 1'b0;
            frame_error_o <= 1'b0;
            if (fall) shreg <= full;
            if (state == IDLE) begin
                tcnt <= '0;
                if (fall) bit_cnt <= 4'd1;
            end else if (frame_done) begin
                bit_cnt <= '0;
                tcnt    <= '0;
                if (good) begin
                    byte_valid_o <= 1'b1;
                    rx_byte      <= full[8:1];
                end else begin
                    frame_error_o <= 1'b1;
                end
            end else if (timeout) begin
                bit_cnt       <= '0;
                tcnt          <= '0;
                shreg         <= '0;
                frame_error_o <= 1'b1;
            end else if (fall) begin
                bit_cnt <= bit_cnt + 4'd1;
                tcnt    <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    // Scancode decoder: prefix flags, then (ext, code) lookup sets key = !break.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ext_pend         <= 1'b0;
            brk_pend         <= 1'b0;
            player_1_move_o  <= '0;
            player_2_move_o  <= '0;
            player_1_shoot_o <= 1'b0;
            player_2_shoot_o <= 1'b0;
        end else if (byte_valid_o) begin
            if (rx_byte == 8'hE0) begin
                ext_pend <= 1'b1;
            end else if (rx_byte == 8'hF0) begin
                brk_pend <= 1'b1;
            end else begin
                case ({ext_pend, rx_byte})
                    9'h01C:  player_1_move_o[3] <= ~brk_pend;
                    9'h023:  player_1_move_o[2] <= ~brk_pend;
                    9'h01D:  player_1_move_o[1] <= ~brk_pend;
                    9'h01B:  player_1_move_o[0] <= ~brk_pend;
                    9'h029:  player_1_shoot_o   <= ~brk_pend;
                    9'h05A:  player_2_shoot_o   <= ~brk_pend;
                    9'h16B:  player_2_move_o[3] <= ~brk_pend;
                    9'h174:  player_2_move_o[2] <= ~brk_pend;
                    9'h175:  player_2_move_o[1] <= ~brk_pend;
                    9'h172:  player_2_move_o[0] <= ~brk_pend;
                    default: ;
                endcase
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: sends PS/2 frames bit by bit and
// checks key states, pulse counts, latency, timeout, glitch and reset cases.
module tb_ps2_key_decoder;

    localparam int FILTER_LEN = 4;
    localparam int TIMEOUT    = 400;
    localparam int HALF       = 20;
    localparam int GAP        = 30;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       ps2_clk_i = 1'b1;
    logic       ps2_data_i = 1'b1;
    logic [3:0] player_1_move_o;
    logic [3:0] player_2_move_o;
    logic       player_1_shoot_o;
    logic       player_2_shoot_o;
    logic       byte_valid_o;
    logic       frame_error_o;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int bv_cnt = 0;
    int err_cnt = 0;
    int bv_cyc = 0;
    int p1_chg_cyc = 0;
    logic [3:0] prev_p1 = 4'b0;
    int bv0;
    int err0;

    ps2_key_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .ps2_clk_i(ps2_clk_i),
        .ps2_data_i(ps2_data_i),
        .player_1_move_o(player_1_move_o),
        .player_2_move_o(player_2_move_o),
        .player_1_shoot_o(player_1_shoot_o),
        .player_2_shoot_o(player_2_shoot_o),
        .byte_valid_o(byte_valid_o),
        .frame_error_o(frame_error_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters and timestamps, sampled on the falling edge.
    always @(negedge clk) begin
        if (byte_valid_o) begin
            bv_cnt <= bv_cnt + 1;
            bv_cyc <= cyc;
        end
        if (frame_error_o) err_cnt <= err_cnt + 1;
        if (player_1_move_o !== prev_p1) begin
            prev_p1    <= player_1_move_o;
            p1_chg_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data_i = b;
        repeat (HALF) @(negedge clk);
        ps2_clk_i = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk_i = 1'b1;
    endtask

    task automatic send_bits(input logic [7:0] b, input logic flip, input int n);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ flip, b, 1'b0};
        for (int i = 0; i < n; i++) ps2_bit(f[i]);
        ps2_data_i = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(b, 1'b0, 11);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        reset_i = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_p1", 32'(player_1_move_o), 32'h0);
        check("reset_p2", 32'(player_2_move_o), 32'h0);
        check("reset_shoot", 32'({player_1_shoot_o, player_2_shoot_o}), 32'h0);
        check("reset_pulses", 32'(bv_cnt + err_cnt), 32'h0);

        // 1: W make, latency, repeat make, break, break of unheld key
        send(8'h1D);
        check("w_make", 32'(player_1_move_o), 32'h2);
        check("w_bv_count", 32'(bv_cnt), 32'd1);
        check("w_latency", 32'(p1_chg_cyc - bv_cyc), 32'd1);
        send(8'h1D);
        check("w_repeat", 32'(player_1_move_o), 32'h2);
        send(8'hF0); send(8'h1D);
        check("w_break", 32'(player_1_move_o), 32'h0);
        check("bv_count4", 32'(bv_cnt), 32'd4);
        send(8'hF0); send(8'h1B);
        check("unheld_break", 32'(player_1_move_o), 32'h0);

        // 2: extended up plus space held together, then extended break
        send(8'hE0); send(8'h75); send(8'h29);
        check("p2_up", 32'(player_2_move_o), 32'h2);
        check("space_held", 32'(player_1_shoot_o), 32'h1);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("p2_up_break", 32'(player_2_move_o), 32'h0);
        check("space_still", 32'(player_1_shoot_o), 32'h1);

        // 3: parity error then good frame
        bv0 = bv_cnt; err0 = err_cnt;
        send_bits(8'h1C, 1'b1, 11);
        check("par_err", 32'(err_cnt - err0), 32'd1);
        check("par_no_bv", 32'(bv_cnt - bv0), 32'd0);
        check("par_no_key", 32'(player_1_move_o), 32'h0);
        send(8'h1C);
        check("a_make", 32'(player_1_move_o), 32'h8);
        send(8'hF0); send(8'h1C);
        check("a_break", 32'(player_1_move_o), 32'h0);

        // 4: timeout after 5 bits, then recovery
        err0 = err_cnt; bv0 = bv_cnt;
        send_bits(8'h23, 1'b0, 5);
        repeat (TIMEOUT + 10) @(negedge clk);
        check("timeout_err", 32'(err_cnt - err0), 32'd1);
        check("timeout_no_bv", 32'(bv_cnt - bv0), 32'd0);
        send(8'h23);
        check("d_make", 32'(player_1_move_o), 32'h4);
        send(8'hF0); send(8'h23);
        check("d_break", 32'(player_1_move_o), 32'h0);

        // 5: short clock glitch, then mid-frame reset after E0
        bv0 = bv_cnt; err0 = err_cnt;
        @(negedge clk);
        ps2_clk_i = 1'b0;
        repeat (FILTER_LEN - 1) @(negedge clk);
        ps2_clk_i = 1'b1;
        repeat (GAP) @(negedge clk);
        send(8'h1B);
        check("glitch_s_make", 32'(player_1_move_o), 32'h1);
        check("glitch_pulses", 32'(bv_cnt - bv0 + err_cnt - err0), 32'd1);
        send(8'hE0);
        send_bits(8'h75, 1'b0, 5);
        reset_i = 1'b1;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_p1", 32'(player_1_move_o), 32'h0);
        check("rst_shoot1", 32'(player_1_shoot_o), 32'h0);
        bv0 = bv_cnt;
        send(8'h75);
        check("rst_75_bv", 32'(bv_cnt - bv0), 32'd1);
        check("rst_75_p2", 32'(player_2_move_o), 32'h0);
        check("rst_75_p1", 32'(player_1_move_o), 32'h0);

        // 6: Enter, extended Enter, break; unmapped byte clears break flag
        send(8'h5A);
        check("enter_make", 32'(player_2_shoot_o), 32'h1);
        send(8'hE0); send(8'h5A);
        check("enter_ext", 32'(player_2_shoot_o), 32'h1);
        send(8'hF0); send(8'h5A);
        check("enter_break", 32'(player_2_shoot_o), 32'h0);
        send(8'hF0); send(8'hAA); send(8'h29);
        check("aa_clears_brk", 32'(player_1_shoot_o), 32'h1);
        send(8'hF0); send(8'h29);
        check("space_break", 32'(player_1_shoot_o), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
